exec_wb: RTL and testbench

EXEC_WB -- requirements
Module: exec_wb

---
 rtl/pcpu_wb_pkg.sv | 46 ++++
 rtl/exec_wb_cond_eval.sv | 34 +++
 rtl/exec_wb.sv | 171 +++++++++++++++++
 tb/tb_exec_wb.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpu_wb_pkg.sv
// pcpu_wb_pkg: shared definitions for the execute/writeback stage.
//   - architectural flag bit positions inside the 5-bit flag vector
//   - branch condition code constants
//   - the buffered entry layout (entry_t) and its width
package pcpu_wb_pkg;

  // Flag vector layout {PAR,OVF,NEG,CARRY,ZERO} = bits 4..0
  localparam int FLAG_Z    = 0;
  localparam int FLAG_C    = 1;
  localparam int FLAG_N    = 2;
  localparam int FLAG_V    = 3;
  localparam int FLAG_P    = 4;
  localparam int NUM_FLAGS = 5;

  // Branch condition codes
  localparam logic [3:0] COND_AL  = 4'd0;   // always
  localparam logic [3:0] COND_Z   = 4'd1;
  localparam logic [3:0] COND_NZ  = 4'd2;
  localparam logic [3:0] COND_C   = 4'd3;
  localparam logic [3:0] COND_NC  = 4'd4;
  localparam logic [3:0] COND_N   = 4'd5;
  localparam logic [3:0] COND_NN  = 4'd6;
  localparam logic [3:0] COND_V   = 4'd7;
  localparam logic [3:0] COND_NV  = 4'd8;
  localparam logic [3:0] COND_P   = 4'd9;
  localparam logic [3:0] COND_NP  = 4'd10;
  localparam logic [3:0] COND_LT  = 4'd11;  // N ^ V
  localparam logic [3:0] COND_GE  = 4'd12;  // !(N ^ V)
  // 13..15 never taken

  localparam int FIFO_DEPTH = 2;

  typedef struct packed {
    logic [15:0]          result;
    logic [NUM_FLAGS-1:0] flags;
    logic                 flags_we;
    logic [2:0]           rd;
    logic                 rd_we;
    logic                 is_br;
    logic [3:0]           cond;
    logic [15:0]          target;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/exec_wb_cond_eval.sv
// cond_eval: purely combinational branch condition evaluation.
// Ports:
//   flags  in  5  architectural flags {PAR,OVF,NEG,CARRY,ZERO}
//   cond   in  4  condition code
//   taken  out 1  condition satisfied
import pcpu_wb_pkg::*;

module cond_eval (
  input  logic [NUM_FLAGS-1:0] flags,
  input  logic [3:0]           cond,
  output logic                 taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_Z:  taken = flags[FLAG_Z];
      COND_NZ: taken = ~flags[FLAG_Z];
      COND_C:  taken = flags[FLAG_C];
      COND_NC: taken = ~flags[FLAG_C];
      COND_N:  taken = flags[FLAG_N];
      COND_NN: taken = ~flags[FLAG_N];
      COND_V:  taken = flags[FLAG_V];
      COND_NV: taken = ~flags[FLAG_V];
      COND_P:  taken = flags[FLAG_P];
      COND_NP: taken = ~flags[FLAG_P];
      COND_LT: taken = flags[FLAG_N] ^ flags[FLAG_V];
      COND_GE: taken = ~(flags[FLAG_N] ^ flags[FLAG_V]);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_wb.sv
// exec_wb: execute -> writeback stage with a 2-entry in-order buffer.
// Entries are accepted on in_valid && in_ready and committed from the head
// whenever wb_ready is high. A commit may write the register file, update the
// architectural flags and resolve a conditional branch; a taken branch
// discards every younger entry (buffered or arriving on the same edge).
// rf_we / br_taken / flush are registered one-cycle pulses that follow the
// committing edge.
//
// Optional feature: define EXEC_WB_PERF_CNT_EN to add commit_cnt / flush_cnt.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid/in_ready      entry handshake from execute
//   in_result, in_flags, in_flags_we, in_rd, in_rd_we,
//   in_is_br, in_cond, in_target   entry payload
//   wb_ready               writeback side may commit this cycle
//   rf_we/rf_waddr/rf_wdata         register file write
//   flags_q                architectural flags
//   br_taken/br_target     taken-branch pulse and target
//   flush                  younger entries discarded
//   commit_cnt/flush_cnt   (EXEC_WB_PERF_CNT_EN only) performance counters
import pcpu_wb_pkg::*;

module exec_wb (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_result,
  input  logic [NUM_FLAGS-1:0] in_flags,
  input  logic                 in_flags_we,
  input  logic [2:0]           in_rd,
  input  logic                 in_rd_we,
  input  logic                 in_is_br,
  input  logic [3:0]           in_cond,
  input  logic [15:0]          in_target,
  input  logic                 wb_ready,
  output logic                 rf_we,
  output logic [2:0]           rf_waddr,
  output logic [15:0]          rf_wdata,
  output logic [NUM_FLAGS-1:0] flags_q,
  output logic                 br_taken,
  output logic [15:0]          br_target,
  output logic                 flush
`ifdef EXEC_WB_PERF_CNT_EN
  ,
  output logic [15:0]          commit_cnt,
  output logic [15:0]          flush_cnt
`endif
);

  entry_t     mem [FIFO_DEPTH];
  entry_t     in_entry;
  entry_t     head;
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;

  logic accept;
  logic commit;
  logic head_cond;
  logic take_branch;
  logic head_writes;

  always_comb begin
    in_entry          = '0;
    in_entry.result   = in_result;
    in_entry.flags    = in_flags;
    in_entry.flags_we = in_flags_we;
    in_entry.rd       = in_rd;
    in_entry.rd_we    = in_rd_we;
    in_entry.is_br    = in_is_br;
    in_entry.cond     = in_cond;
    in_entry.target   = in_target;
  end

  assign in_ready = (count < 2'd2);
  assign accept   = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign commit   = (count != 2'd0) && wb_ready;

  // The condition sees flags_q before this entry's own flag update lands.
  cond_eval u_cond_eval (
    .flags (flags_q),
    .cond  (head.cond),
    .taken (head_cond)
  );

  assign take_branch = commit && head.is_br && head_cond;
  // Branches never write the register file, taken or not.
  assign head_writes = commit && head.rd_we && !head.is_br;

  // Buffer storage and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (take_branch) begin
      // Drops the rest of the buffer and any entry accepted on this edge.
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= in_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (commit) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({accept, commit})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Commit side effects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we     <= 1'b0;
      rf_waddr  <= 3'd0;
      rf_wdata  <= 16'd0;
      flags_q   <= '0;
      br_taken  <= 1'b0;
      br_target <= 16'd0;
      flush     <= 1'b0;
    end else begin
      rf_we    <= head_writes;
      br_taken <= take_branch;
      flush    <= take_branch;
      if (head_writes) begin
        rf_waddr <= head.rd;
        rf_wdata <= head.result;
      end
      if (take_branch) begin
        br_target <= head.target;
      end
      if (commit && head.flags_we) begin
        flags_q <= head.flags;
      end
    end
  end

`ifdef EXEC_WB_PERF_CNT_EN
  logic [15:0] n_discard;

  // On a taken branch at most one other entry is buffered (count == 2),
  // plus the entry possibly accepted on the same edge.
  assign n_discard = {15'd0, (count == 2'd2)} + {15'd0, accept};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_cnt <= 16'd0;
      flush_cnt  <= 16'd0;
    end else begin
      if (commit) begin
        commit_cnt <= commit_cnt + 16'd1;
      end
      if (take_branch) begin
        flush_cnt <= flush_cnt + n_discard;
      end
    end
  end
`endif

endmodule

// File: tb/tb_exec_wb.sv
// tb_exec_wb: directed self-checking bench for exec_wb.
module tb_exec_wb;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic [4:0]  in_flags;
  logic        in_flags_we;
  logic [2:0]  in_rd;
  logic        in_rd_we;
  logic        in_is_br;
  logic [3:0]  in_cond;
  logic [15:0] in_target;
  logic        wb_ready;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [4:0]  flags_q;
  logic        br_taken;
  logic [15:0] br_target;
  logic        flush;
`ifdef EXEC_WB_PERF_CNT_EN
  logic [15:0] commit_cnt;
  logic [15:0] flush_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  exec_wb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_flags    (in_flags),
    .in_flags_we (in_flags_we),
    .in_rd       (in_rd),
    .in_rd_we    (in_rd_we),
    .in_is_br    (in_is_br),
    .in_cond     (in_cond),
    .in_target   (in_target),
    .wb_ready    (wb_ready),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .flags_q     (flags_q),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .flush       (flush)
`ifdef EXEC_WB_PERF_CNT_EN
    ,
    .commit_cnt  (commit_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [15:0] res, input logic [2:0] rd, input logic rd_we,
                       input logic [4:0] fl, input logic fl_we,
                       input logic is_br, input logic [3:0] cond, input logic [15:0] tgt);
    in_valid    = 1'b1;
    in_result   = res;
    in_rd       = rd;
    in_rd_we    = rd_we;
    in_flags    = fl;
    in_flags_we = fl_we;
    in_is_br    = is_br;
    in_cond     = cond;
    in_target   = tgt;
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    in_result   = 16'd0;
    in_rd       = 3'd0;
    in_rd_we    = 1'b0;
    in_flags    = 5'd0;
    in_flags_we = 1'b0;
    in_is_br    = 1'b0;
    in_cond     = 4'd0;
    in_target   = 16'd0;
  endtask

  initial begin
    rst_n    = 1'b0;
    wb_ready = 1'b0;
    idle();
    tick();
    tick();
    // Reset state
    chk("rst_in_ready", in_ready, 16'd1);
    chk("rst_flags", flags_q, 16'd0);
    chk("rst_rf_we", rf_we, 16'd0);
    chk("rst_br_taken", br_taken, 16'd0);
    chk("rst_flush", flush, 16'd0);
    chk("rst_waddr", rf_waddr, 16'd0);
    chk("rst_wdata", rf_wdata, 16'd0);
    chk("rst_br_target", br_target, 16'd0);
    rst_n = 1'b1;

    // Simple register write
    wb_ready = 1'b1;
    offer(16'h1234, 3'd3, 1'b1, 5'h00, 1'b0, 1'b0, 4'd0, 16'h0000);
    tick();
    idle();
    chk("wr_not_yet", rf_we, 16'd0);
    tick();
    chk("wr_we", rf_we, 16'd1);
    chk("wr_addr", rf_waddr, 16'd3);
    chk("wr_data", rf_wdata, 16'h1234);
    tick();
    chk("wr_pulse_end", rf_we, 16'd0);

    // Flags update then branch on Z (taken); branch with rd_we must not write
    offer(16'h0000, 3'd0, 1'b0, 5'h01, 1'b1, 1'b0, 4'd0, 16'h0000);
    tick();
    offer(16'h9999, 3'd4, 1'b1, 5'h00, 1'b0, 1'b1, 4'd1, 16'h0040);
    tick();
    idle();
    chk("fl_flags", flags_q, 16'h0001);
    chk("fl_no_we", rf_we, 16'd0);
    tick();
    chk("bz_taken", br_taken, 16'd1);
    chk("bz_flush", flush, 16'd1);
    chk("bz_target", br_target, 16'h0040);
    chk("bz_no_we", rf_we, 16'd0);
    tick();
    chk("bz_pulse_end", br_taken, 16'd0);
    chk("bz_flush_end", flush, 16'd0);

    // Branch on !Z with Z set: not taken, target register unchanged
    offer(16'h0000, 3'd0, 1'b0, 5'h00, 1'b0, 1'b1, 4'd2, 16'h0050);
    tick();
    idle();
    tick();
    chk("bnz_taken", br_taken, 16'd0);
    chk("bnz_flush", flush, 16'd0);
    chk("bnz_target", br_target, 16'h0040);

    // N set, cond 11 (N^V) taken; cond 13 never
    offer(16'h0000, 3'd0, 1'b0, 5'h04, 1'b1, 1'b0, 4'd0, 16'h0000);
    tick();
    offer(16'h0000, 3'd0, 1'b0, 5'h00, 1'b0, 1'b1, 4'd11, 16'h0060);
    tick();
    idle();
    tick();
    chk("blt_taken", br_taken, 16'd1);
    chk("blt_target", br_target, 16'h0060);
    tick();
    offer(16'h0000, 3'd0, 1'b0, 5'h00, 1'b0, 1'b1, 4'd13, 16'h0070);
    tick();
    idle();
    tick();
    chk("bnever_taken", br_taken, 16'd0);
    chk("bnever_flags", flags_q, 16'h0004);

    // Backpressure: 3 offers with wb_ready low
    wb_ready = 1'b0;
    offer(16'h1111, 3'd1, 1'b1, 5'h00, 1'b0, 1'b0, 4'd0, 16'h0000);
    tick();
    offer(16'h2222, 3'd2, 1'b1, 5'h00, 1'b0, 1'b0, 4'd0, 16'h0000);
    tick();
    chk("bp_full", in_ready, 16'd0);
    offer(16'h5555, 3'd5, 1'b1, 5'h00, 1'b0, 1'b0, 4'd0, 16'h0000);
    tick();
    chk("bp_hold_we", rf_we, 16'd0);
    chk("bp_hold_ready", in_ready, 16'd0);
    wb_ready = 1'b1;
    tick();
    chk("bp_c1_we", rf_we, 16'd1);
    chk("bp_c1_addr", rf_waddr, 16'd1);
    chk("bp_c1_data", rf_wdata, 16'h1111);
    chk("bp_c1_ready", in_ready, 16'd1);
    tick();
    idle();
    chk("bp_c2_addr", rf_waddr, 16'd2);
    chk("bp_c2_data", rf_wdata, 16'h2222);
    tick();
    chk("bp_c3_we", rf_we, 16'd1);
    chk("bp_c3_addr", rf_waddr, 16'd5);
    chk("bp_c3_data", rf_wdata, 16'h5555);
    tick();
    chk("bp_done_we", rf_we, 16'd0);
    chk("bp_done_ready", in_ready, 16'd1);

    // Flush of a buffered younger entry
    wb_ready = 1'b0;
    offer(16'h0000, 3'd0, 1'b0, 5'h00, 1'b0, 1'b1, 4'd0, 16'h0080);
    tick();
    offer(16'h6666, 3'd6, 1'b1, 5'h00, 1'b0, 1'b0, 4'd0, 16'h0000);
    tick();
    idle();
    wb_ready = 1'b1;
    tick();
    chk("fl1_taken", br_taken, 16'd1);
    chk("fl1_flush", flush, 16'd1);
    chk("fl1_target", br_target, 16'h0080);
    chk("fl1_empty", in_ready, 16'd1);
    tick();
    chk("fl1_no_we_a", rf_we, 16'd0);
    chk("fl1_flush_end", flush, 16'd0);
    tick();
    chk("fl1_no_we_b", rf_we, 16'd0);

    // Flush of an entry accepted on the same edge as the taken branch
    offer(16'h0000, 3'd0, 1'b0, 5'h00, 1'b0, 1'b1, 4'd0, 16'h0090);
    tick();
    offer(16'h7777, 3'd7, 1'b1, 5'h00, 1'b0, 1'b0, 4'd0, 16'h0000);
    tick();
    idle();
    chk("fl2_taken", br_taken, 16'd1);
    chk("fl2_target", br_target, 16'h0090);
    tick();
    chk("fl2_no_we_a", rf_we, 16'd0);
    tick();
    chk("fl2_no_we_b", rf_we, 16'd0);
    chk("fl2_wdata", rf_wdata, 16'h5555);

    // Reset in the middle of operation
    wb_ready = 1'b0;
    offer(16'haaaa, 3'd1, 1'b1, 5'h00, 1'b0, 1'b0, 4'd0, 16'h0000);
    tick();
    offer(16'hbbbb, 3'd2, 1'b1, 5'h00, 1'b0, 1'b0, 4'd0, 16'h0000);
    tick();
    idle();
    chk("mr_full", in_ready, 16'd0);
    chk("mr_flags_pre", flags_q, 16'h0004);
    rst_n = 1'b0;
    #1;
    chk("mr_flags", flags_q, 16'd0);
    chk("mr_ready", in_ready, 16'd1);
    chk("mr_waddr", rf_waddr, 16'd0);
    chk("mr_br_target", br_target, 16'd0);
    tick();
    rst_n = 1'b1;
    wb_ready = 1'b1;
    tick();
    chk("mr_no_we_a", rf_we, 16'd0);
    tick();
    chk("mr_no_we_b", rf_we, 16'd0);

    // Branch that also writes flags sees the old flags (Z=0 -> not taken)
    offer(16'h0000, 3'd0, 1'b0, 5'h01, 1'b1, 1'b1, 4'd1, 16'h00a0);
    tick();
    idle();
    tick();
    chk("old_fl_taken", br_taken, 16'd0);
    chk("old_fl_flags", flags_q, 16'h0001);
    offer(16'h0000, 3'd0, 1'b0, 5'h00, 1'b0, 1'b1, 4'd1, 16'h00b0);
    tick();
    idle();
    tick();
    chk("new_fl_taken", br_taken, 16'd1);
    chk("new_fl_target", br_target, 16'h00b0);
    tick();

`ifdef EXEC_WB_PERF_CNT_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("pc_rst_commit", commit_cnt, 16'd0);
    chk("pc_rst_flush", flush_cnt, 16'd0);
    wb_ready = 1'b1;
    offer(16'h0001, 3'd0, 1'b0, 5'h00, 1'b0, 1'b0, 4'd0, 16'h0000);
    repeat (16'hffff) tick();
    idle();
    tick();
    chk("pc_ffff", commit_cnt, 16'hffff);
    offer(16'h0001, 3'd0, 1'b0, 5'h00, 1'b0, 1'b0, 4'd0, 16'h0000);
    tick();
    idle();
    tick();
    chk("pc_wrap", commit_cnt, 16'h0000);
    wb_ready = 1'b0;
    offer(16'h0000, 3'd0, 1'b0, 5'h00, 1'b0, 1'b1, 4'd0, 16'h00c0);
    tick();
    offer(16'h0001, 3'd1, 1'b1, 5'h00, 1'b0, 1'b0, 4'd0, 16'h0000);
    tick();
    idle();
    wb_ready = 1'b1;
    tick();
    chk("pc_br_commit", commit_cnt, 16'd1);
    chk("pc_flush_cnt", flush_cnt, 16'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
